fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Sequences the combinational instruction ROM for the out-of-order core. Holds the PC, drives the
//   ROM word address, and buffers fetched {pc, instr} pairs in a small FIFO that feeds decode/rename
//   through a valid/ready handshake. Handles branch redirects (flush), end-of-trace halt and end-of-ROM.
// PARAMETERS
//   DEPTH     4   fetch FIFO entries; power of 2, >= 2
//   ADDR_W    8   ROM word-address width (ROM holds 2**ADDR_W 32-bit words)
//   RESET_PC  0   word address fetched first after start
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   start_i      in   1       pulse: leave IDLE and begin fetching at RESET_PC
//   flush_i      in   1       redirect: discard FIFO, refetch from flush_pc_i
//   flush_pc_i   in   32      redirect byte address; bits [ADDR_W+1:2] used, others ignored
//   rom_addr_o   out  ADDR_W  ROM word address (= PC register)
//   rom_data_i   in   32      ROM data, combinational from rom_addr_o (same cycle)
//   out_valid_o  out  1       FIFO head valid
//   out_ready_i  in   1       decode accepts head this cycle
//   out_instr_o  out  32      head instruction
//   out_pc_o     out  32      head byte address = {zeros, word_addr, 2'b00}
//   halted_o     out  1       in HALT state
// BEHAVIOUR
//   - Reset: state IDLE, pc=RESET_PC, FIFO empty, out_valid_o=0, halted_o=0, rom_addr_o=RESET_PC.
//   - States: IDLE -(start_i)-> FETCH; FETCH -(end condition)-> HALT; any -(flush_i)-> FETCH.
//     start_i ignored outside IDLE.
//   - FETCH, per cycle: push = (rom_data_i != 0) && (!full || pop). On push:
//       * write {pc, rom_data_i};
//       * pc <= pc + 1.
//     If push does not occur, pc holds.
//   - pop = out_valid_o && out_ready_i. A pop and a push may occur in the same cycle, including when
//     the FIFO is full; the count is then unchanged.
//   - End of trace: rom_data_i == 32'h0 in FETCH -> no push, go to HALT, pc holds. Trace images are
//     zero-padded.
//   - End of ROM: a push at pc = 2**ADDR_W-1 -> go to HALT and pc wraps to 0. No further fetch
//     occurs until a flush.
//   - HALT: no pushes; the FIFO keeps draining through pops; halted_o=1.
//   - flush_i has priority over push, pop and start in the same cycle:
//       * FIFO emptied (out_valid_o=0 next cycle);
//       * pc <= flush_pc_i[ADDR_W+1:2];
//       * state <= FETCH;
//       * halted_o=0 next cycle.
//     A head presented in the flush cycle with out_ready_i=1 counts as consumed by decode; this is
//     legal, because decode also squashes it.
//   - Latency: the instruction at pc is visible at out_* 1 cycle after the push edge (registered FIFO).
//     Back-to-back throughput is 1 instr/cycle.
//   - out_instr_o and out_pc_o are don't-care while out_valid_o=0.
//   - Reset asserted mid-operation returns everything to the reset state immediately (async).
//   - FIFO pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.
// CONFIGURATION
//   FETCH_STATS_EN defined: adds two output ports:
//     - fetch_count_o[31:0]: pushes since reset;
//     - stall_count_o[31:0]: FETCH cycles where full && !pop && rom_data_i != 0.
//     Both reset to 0, wrap at 2**32, are not cleared by flush, and are valid in every state.
//   FETCH_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.
// TESTING
//   1. ROM words 0..3 = 0x11,0x22,0x33,0x44, word 4 = 0; start, out_ready_i=1 ->
//      out_* = (0x000,0x11),(0x004,0x22),(0x008,0x33),(0x00C,0x44) on consecutive cycles,
//      then halted_o=1, out_valid_o=0.
//   2. Same ROM, out_ready_i=0 for 10 cycles after start ->
//      exactly 4 entries buffered, rom_addr_o holds at 4.
//      With FETCH_STATS_EN: stall_count_o=0 because word 4=0 halts.
//      With 8 nonzero words: stall_count_o counts each full cycle. Then ready=1 -> in-order drain.
//   3. Flush with flush_pc_i=0x040 while the FIFO holds 3 entries ->
//      out_valid_o=0 next cycle, then the first out_pc_o=0x040 with the instruction at word 16.
//   4. ROM fully nonzero, continuous ready ->
//      word 255 delivered with out_pc_o=0x3FC, then halted_o=1, rom_addr_o=0, no further pushes.
//   5. Flush issued while halted_o=1 -> resumes FETCH at the target; halted_o=0 next cycle.
//   6. rst asserted mid-stream with 2 entries buffered ->
//      out_valid_o=0 and rom_addr_o=RESET_PC without a clock edge; after release, stays IDLE until start_i.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, combinational ROM addressing and a small {pc, instr} FIFO toward decode.
// Optional FETCH_STATS_EN adds push/stall counters as fetch_count_o / stall_count_o.
module fetch_sequencer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [31:0]       out_pc_o,
`ifdef FETCH_STATS_EN
  output logic [31:0]       fetch_count_o,
  output logic [31:0]       stall_count_o,
`endif
  output logic              halted_o
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];

  logic full, word_nz, pop, push, last_word;
  logic unused_flush_bits;

  assign full        = count == (PTR_W+1)'(DEPTH);
  assign word_nz     = |rom_data_i;
  assign out_valid_o = count != '0;
  assign pop         = out_valid_o && out_ready_i;
  assign push        = (state == FETCH) && !flush_i && word_nz && (!full || pop);
  assign last_word   = &pc;

  assign rom_addr_o  = pc;
  assign out_instr_o = instr_mem[rd_ptr];
  assign out_pc_o    = {{(30-ADDR_W){1'b0}}, pc_mem[rd_ptr], 2'b00};
  assign unused_flush_bits = ^{flush_pc_i[31:ADDR_W+2], flush_pc_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= ADDR_W'(RESET_PC);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted_o <= 1'b0;
    end else if (flush_i) begin
      // Redirect wins over everything; a head taken this cycle is squashed downstream anyway.
      state    <= FETCH;
      pc       <= flush_pc_i[ADDR_W+1:2];
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted_o <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (start_i) state <= FETCH;
        FETCH: if (!word_nz || (push && last_word)) begin
                 state    <= HALT;
                 halted_o <= 1'b1;
               end
        default: ;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + 1'b1;  // wraps to 0 after the last ROM word
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= rom_data_i;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (push) fetch_count_o <= fetch_count_o + 1'b1;
      if (state == FETCH && full && !pop && word_nz) stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif
endmodule
